// File: rtl/adc_spi_pkg.sv
// Shared types and default constants for the ADC SPI reader.
package adc_spi_pkg;

  localparam int DATA_WIDTH_DEF   = 12;
  localparam int LEAD_BITS_DEF    = 4;
  localparam int SCLK_DIV_DEF     = 4;
  localparam int QUIET_CYCLES_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    QUIET
  } state_e;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/adc_spi_reader_if.sv
// ADC serial bus: chip select, serial clock and serial data.
interface adc_spi_reader_if;
  logic adc_cs_no;
  logic adc_sclk_o;
  logic adc_sdo_i;

  modport master (output adc_cs_no, output adc_sclk_o, input adc_sdo_i);
  modport slave  (input adc_cs_no, input adc_sclk_o, output adc_sdo_i);
endinterface

// File: rtl/adc_sclk_gen.sv
// SCLK divider: half-period of SclkDiv cycles, idles high.
// start_i forces the first falling edge; stop_i parks SCLK high after the
// last high phase. rise_o/fall_o flag the clk_i edge on which SCLK toggles.
module adc_sclk_gen
  import adc_spi_pkg::*;
#(
  parameter int SclkDiv = SCLK_DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic start_i,
  input  logic stop_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CntW = cnt_w(SclkDiv - 1);

  logic [CntW-1:0] cnt_q;
  logic            tick;

  assign tick   = en_i && (cnt_q == CntW'(SclkDiv - 1));
  assign rise_o = tick && !sclk_o;
  assign fall_o = tick && sclk_o;

  // Half-period counter and SCLK toggle; held high whenever disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sclk_o <= 1'b1;
    end else if (start_i) begin
      cnt_q  <= '0;
      sclk_o <= 1'b0;
    end else if (!en_i) begin
      cnt_q  <= '0;
      sclk_o <= 1'b1;
    end else if (tick) begin
      cnt_q  <= '0;
      sclk_o <= !sclk_o || stop_i;
    end else begin
      cnt_q  <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// ADC SPI frame reader: one trigger -> one CS-framed read of
// LeadBits+DataWidth bits, lead bits dropped, result on data_o with eoc_o.
// Optional lost-trigger flag enabled by defining ADC_SPI_READER_OVERRUN_EN.
module adc_spi_reader
  import adc_spi_pkg::*;
#(
  parameter int DataWidth   = DATA_WIDTH_DEF,
  parameter int LeadBits    = LEAD_BITS_DEF,
  parameter int SclkDiv     = SCLK_DIV_DEF,
  parameter int QuietCycles = QUIET_CYCLES_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 trigger_i,
  input  logic                 ovr_clr_i,
  adc_spi_reader_if.master     spi,
  output logic [DataWidth-1:0] data_o,
  output logic                 eoc_o,
  output logic                 busy_o,
  output logic                 overrun_o
);

  localparam int FrameBits = LeadBits + DataWidth;
  localparam int BitW      = cnt_w(FrameBits);
  localparam int CntMax    = (SclkDiv > QuietCycles) ? SclkDiv - 1 : QuietCycles - 1;
  localparam int CntW      = cnt_w(CntMax);

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [BitW-1:0]       bit_cnt_q;
  logic [FrameBits-1:0]  shift_q;
  logic                  cs_nq;
  logic                  setup_end;
  logic                  last_bit;
  logic                  sclk_en;
  logic                  sclk_rise;
  logic                  sclk_fall;

  assign setup_end     = (state_q == SETUP) && (cnt_q == CntW'(SclkDiv - 1));
  assign last_bit      = (bit_cnt_q == BitW'(FrameBits));
  assign sclk_en       = (state_q == SHIFT);
  assign spi.adc_cs_no = cs_nq;

  adc_sclk_gen #(
    .SclkDiv (SclkDiv)
  ) u_sclk_gen (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (sclk_en),
    .start_i (setup_end),
    .stop_i  (last_bit),
    .sclk_o  (spi.adc_sclk_o),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  // Frame sequencer; CS, busy, data and EOC are all registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      cs_nq     <= 1'b1;
      busy_o    <= 1'b0;
      eoc_o     <= 1'b0;
      data_o    <= '0;
    end else begin
      eoc_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trigger_i) begin
            state_q   <= SETUP;
            cs_nq     <= 1'b0;
            busy_o    <= 1'b1;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
          end
        end
        SETUP: begin
          if (setup_end) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + CntW'(1);
          end
        end
        SHIFT: begin
          // SDO is taken on the edge where SCLK rises.
          if (sclk_rise) begin
            shift_q   <= {shift_q[FrameBits-2:0], spi.adc_sdo_i};
            bit_cnt_q <= bit_cnt_q + BitW'(1);
          end
          // Frame closes at the end of the last high phase.
          if (sclk_fall && last_bit) begin
            state_q <= DONE;
            cs_nq   <= 1'b1;
          end
        end
        DONE: begin
          data_o  <= shift_q[DataWidth-1:0];
          eoc_o   <= 1'b1;
          state_q <= QUIET;
          cnt_q   <= '0;
        end
        QUIET: begin
          if (cnt_q == CntW'(QuietCycles - 1)) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cs_nq   <= 1'b1;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADC_SPI_READER_OVERRUN_EN
  // Sticky lost-trigger flag; a new loss beats a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  overrun_o <= 1'b0;
    else if (trigger_i && busy_o) overrun_o <= 1'b1;
    else if (ovr_clr_i)           overrun_o <= 1'b0;
  end
`else
  logic unused_ovr_clr;
  assign unused_ovr_clr = ovr_clr_i;
  assign overrun_o      = 1'b0;
`endif

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader: default instance plus a SclkDiv=1 one.
module tb_adc_spi_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, trig0, clr0, eoc0, busy0, ovr0;
  logic [11:0] data0;
  logic        trig1, clr1, eoc1, busy1, ovr1;
  logic [11:0] data1;
  logic [15:0] frame0, frame1;
  int          rc0, rc1;
  logic        sp0, sp1;
  int          checks = 0, errors = 0, ovr_exp;

  int m_eoc_first, m_eoc_cnt, m_cs_rise, m_cs_relow, m_sclk_rises, m_sclk_low, m_sclk_fall1, m_busy_fall;
  logic s_cs, s_sclk, s_busy, s_eoc, s_ovr;
  logic [11:0] s_data;

  adc_spi_reader_if spi0();
  adc_spi_reader_if spi1();

  adc_spi_reader u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .trigger_i(trig0), .ovr_clr_i(clr0), .spi(spi0),
    .data_o(data0), .eoc_o(eoc0), .busy_o(busy0), .overrun_o(ovr0));

  adc_spi_reader #(.SclkDiv(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .trigger_i(trig1), .ovr_clr_i(clr1), .spi(spi1),
    .data_o(data1), .eoc_o(eoc1), .busy_o(busy1), .overrun_o(ovr1));

  // ADC models: MSB first from CS fall, next bit after every SCLK rise.
  always @(negedge clk) begin
    if (spi0.adc_cs_no) rc0 = 0;
    else if (spi0.adc_sclk_o && !sp0 && rc0 < 15) rc0++;
    sp0 = spi0.adc_sclk_o;
    spi0.adc_sdo_i = frame0[15 - rc0];
    if (spi1.adc_cs_no) rc1 = 0;
    else if (spi1.adc_sclk_o && !sp1 && rc1 < 15) rc1++;
    sp1 = spi1.adc_sclk_o;
    spi1.adc_sdo_i = frame1[15 - rc1];
  end

  task automatic start_frame(input logic [15:0] f);
    frame0 = f;
    @(negedge clk); trig0 = 1'b1;
    @(posedge clk); #1; trig0 = 1'b0;
  endtask

  // Observes nedges edges after a trigger edge; optional extra trigger,
  // clear and reset pulse at given edge numbers (-1 = none).
  task automatic measure(input int nedges, input int trig_at, input int clr_at, input int rst_at);
    logic prev;
    m_eoc_first = -1; m_eoc_cnt = 0; m_cs_rise = -1; m_cs_relow = 0;
    m_sclk_rises = 0; m_sclk_low = 0; m_sclk_fall1 = -1; m_busy_fall = -1;
    prev = spi0.adc_sclk_o;
    for (int n = 1; n <= nedges; n++) begin
      trig0 = (n == trig_at);
      clr0  = (n == clr_at);
      @(posedge clk); #1;
      trig0 = 1'b0; clr0 = 1'b0;
      if (eoc0) begin if (m_eoc_first < 0) m_eoc_first = n; m_eoc_cnt++; end
      if (spi0.adc_cs_no && m_cs_rise < 0) m_cs_rise = n;
      if (!spi0.adc_cs_no && m_cs_rise >= 0) m_cs_relow++;
      if (!spi0.adc_sclk_o) m_sclk_low++;
      if (spi0.adc_sclk_o && !prev) m_sclk_rises++;
      if (!spi0.adc_sclk_o && prev && m_sclk_fall1 < 0) m_sclk_fall1 = n;
      prev = spi0.adc_sclk_o;
      if (!busy0 && m_busy_fall < 0) m_busy_fall = n;
      if (n == rst_at) begin
        rst_n = 1'b0; #1;
        s_cs = spi0.adc_cs_no; s_sclk = spi0.adc_sclk_o; s_busy = busy0;
        s_eoc = eoc0; s_ovr = ovr0; s_data = data0;
        #2; rst_n = 1'b1;
        prev = spi0.adc_sclk_o;
      end
    end
  endtask

  task automatic test_reset;
    #12;
    checks++; if (spi0.adc_cs_no !== 1'b1) begin errors++; $display("FAIL rst_cs got %b want 1", spi0.adc_cs_no); end
    checks++; if (spi0.adc_sclk_o !== 1'b1) begin errors++; $display("FAIL rst_sclk got %b want 1", spi0.adc_sclk_o); end
    checks++; if (data0 !== 12'h000) begin errors++; $display("FAIL rst_data got %h want 000", data0); end
    checks++; if (eoc0 !== 1'b0) begin errors++; $display("FAIL rst_eoc got %b want 0", eoc0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy0); end
    checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b want 0", ovr0); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy0); end
  endtask

  task automatic test_basic;
    start_frame(16'h0ABC);
    checks++; if (spi0.adc_cs_no !== 1'b0) begin errors++; $display("FAIL basic_cs_fall got %b want 0", spi0.adc_cs_no); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy0); end
    measure(160, -1, -1, -1);
    checks++; if (m_eoc_first != 133) begin errors++; $display("FAIL basic_eoc_edge got %0d want 133", m_eoc_first); end
    checks++; if (m_eoc_cnt != 1) begin errors++; $display("FAIL basic_eoc_cnt got %0d want 1", m_eoc_cnt); end
    checks++; if (m_cs_rise != 132) begin errors++; $display("FAIL basic_cs_rise got %0d want 132", m_cs_rise); end
    checks++; if (m_cs_relow != 0) begin errors++; $display("FAIL basic_cs_relow got %0d want 0", m_cs_relow); end
    checks++; if (m_sclk_rises != 16) begin errors++; $display("FAIL basic_sclk_rises got %0d want 16", m_sclk_rises); end
    checks++; if (m_sclk_low != 64) begin errors++; $display("FAIL basic_sclk_low got %0d want 64", m_sclk_low); end
    checks++; if (m_sclk_fall1 != 4) begin errors++; $display("FAIL basic_sclk_fall1 got %0d want 4", m_sclk_fall1); end
    checks++; if (m_busy_fall != 141) begin errors++; $display("FAIL basic_busy_fall got %0d want 141", m_busy_fall); end
    checks++; if (data0 !== 12'hABC) begin errors++; $display("FAIL basic_data got %h want abc", data0); end
  endtask

  task automatic test_lead_bits;
    start_frame(16'hFFFF);
    measure(160, -1, -1, -1);
    checks++; if (data0 !== 12'hFFF) begin errors++; $display("FAIL lead_data got %h want fff", data0); end
    checks++; if (m_eoc_cnt != 1) begin errors++; $display("FAIL lead_eoc_width got %0d want 1", m_eoc_cnt); end
    checks++; if (m_eoc_first != 133) begin errors++; $display("FAIL lead_eoc_edge got %0d want 133", m_eoc_first); end
  endtask

  task automatic test_overrun;
    start_frame(16'h0A5A);
    measure(160, 50, 50, -1);
    checks++; if (m_eoc_first != 133) begin errors++; $display("FAIL ovr_eoc_edge got %0d want 133", m_eoc_first); end
    checks++; if (m_eoc_cnt != 1) begin errors++; $display("FAIL ovr_eoc_cnt got %0d want 1", m_eoc_cnt); end
    checks++; if (m_cs_rise != 132) begin errors++; $display("FAIL ovr_cs_rise got %0d want 132", m_cs_rise); end
    checks++; if (m_sclk_rises != 16) begin errors++; $display("FAIL ovr_sclk_rises got %0d want 16", m_sclk_rises); end
    checks++; if (data0 !== 12'hA5A) begin errors++; $display("FAIL ovr_data got %h want a5a", data0); end
    checks++; if (ovr0 !== ovr_exp[0]) begin errors++; $display("FAIL ovr_flag got %b want %0d", ovr0, ovr_exp); end
    @(negedge clk); clr0 = 1'b1;
    @(posedge clk); #1; clr0 = 1'b0;
    checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", ovr0); end
  endtask

  task automatic test_quiet;
    start_frame(16'h0C3C);
    measure(141, 135, -1, -1);
    checks++; if (m_eoc_first != 133) begin errors++; $display("FAIL quiet_eoc_edge got %0d want 133", m_eoc_first); end
    checks++; if (m_cs_relow != 0) begin errors++; $display("FAIL quiet_cs_relow got %0d want 0", m_cs_relow); end
    checks++; if (m_busy_fall != 141) begin errors++; $display("FAIL quiet_busy_fall got %0d want 141", m_busy_fall); end
    checks++; if (data0 !== 12'hC3C) begin errors++; $display("FAIL quiet_data got %h want c3c", data0); end
    frame0 = 16'h0246;
    trig0 = 1'b1;
    @(posedge clk); #1; trig0 = 1'b0;
    checks++; if (spi0.adc_cs_no !== 1'b0) begin errors++; $display("FAIL quiet_retrig_cs got %b want 0", spi0.adc_cs_no); end
    measure(140, -1, -1, -1);
    checks++; if (m_eoc_first != 133) begin errors++; $display("FAIL quiet_retrig_eoc got %0d want 133", m_eoc_first); end
    checks++; if (data0 !== 12'h246) begin errors++; $display("FAIL quiet_retrig_data got %h want 246", data0); end
  endtask

  task automatic test_reset_mid;
    start_frame(16'h0F0F);
    measure(160, -1, -1, 70);
    checks++; if (s_cs !== 1'b1) begin errors++; $display("FAIL mid_rst_cs got %b want 1", s_cs); end
    checks++; if (s_sclk !== 1'b1) begin errors++; $display("FAIL mid_rst_sclk got %b want 1", s_sclk); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", s_busy); end
    checks++; if (s_eoc !== 1'b0) begin errors++; $display("FAIL mid_rst_eoc got %b want 0", s_eoc); end
    checks++; if (s_ovr !== 1'b0) begin errors++; $display("FAIL mid_rst_ovr got %b want 0", s_ovr); end
    checks++; if (s_data !== 12'h000) begin errors++; $display("FAIL mid_rst_data got %h want 000", s_data); end
    checks++; if (m_eoc_cnt != 0) begin errors++; $display("FAIL mid_rst_no_eoc got %0d want 0", m_eoc_cnt); end
    checks++; if (data0 !== 12'h000) begin errors++; $display("FAIL mid_rst_data_after got %h want 000", data0); end
    start_frame(16'h0321);
    measure(160, -1, -1, -1);
    checks++; if (m_eoc_first != 133) begin errors++; $display("FAIL post_rst_eoc got %0d want 133", m_eoc_first); end
    checks++; if (m_cs_rise != 132) begin errors++; $display("FAIL post_rst_cs_rise got %0d want 132", m_cs_rise); end
    checks++; if (data0 !== 12'h321) begin errors++; $display("FAIL post_rst_data got %h want 321", data0); end
  endtask

  task automatic test_sclkdiv1;
    int first, cnt;
    first = -1; cnt = 0;
    frame1 = 16'h0555;
    @(negedge clk); trig1 = 1'b1;
    @(posedge clk); #1; trig1 = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (eoc1) begin if (first < 0) first = n; cnt++; end
    end
    checks++; if (first != 34) begin errors++; $display("FAIL div1_eoc_edge got %0d want 34", first); end
    checks++; if (cnt != 1) begin errors++; $display("FAIL div1_eoc_cnt got %0d want 1", cnt); end
    checks++; if (data1 !== 12'h555) begin errors++; $display("FAIL div1_data got %h want 555", data1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL div1_busy_end got %b want 0", busy1); end
  endtask

  initial begin
`ifdef ADC_SPI_READER_OVERRUN_EN
    ovr_exp = 1;
`else
    ovr_exp = 0;
`endif
    rst_n = 1'b0; trig0 = 1'b0; clr0 = 1'b0; trig1 = 1'b0; clr1 = 1'b0;
    frame0 = 16'h0000; frame1 = 16'h0000; rc0 = 0; rc1 = 0; sp0 = 1'b1; sp1 = 1'b1;
    test_reset();
    test_basic();
    test_lead_bits();
    test_overrun();
    test_quiet();
    test_reset_mid();
    test_sclkdiv1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
